// File: rtl/smss32_inv40_seq.sv
// smss32_inv40_seq
//   Iterative inverse of the 6-bit SMSS32 power-52 S-box: x = F^-1(y).
//   Computes p = Ninv(y), w = p^40 in the tower field GF((2^3)^2), x = Minv(w).
//   A single shared GF(64) multiplier runs the fixed chain
//     p -> p^2 -> p^4 -> p^5 -> p^10 -> p^20 -> p^40
//   with one multiply per clock, so the timing is data-independent.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   in_data valid
//   in_ready   block can accept an input (IDLE and not in reset)
//   in_data    S-box output y to invert
//   out_valid  out_data valid
//   out_ready  consumer accepts the result
//   out_data   preimage x
//   busy       high in CALC or DONE
//
// Build option:
//   SMSS32_INV_ZEROIZE_EN  clears acc, base and out_data on the output
//                          handshake so no secret-dependent state lingers.

module smss32_inv40_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [5:0] out_data,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [5:0] acc_q, acc_d;
    logic [5:0] base_q, base_d;
    logic [5:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;

    logic [5:0] mul_b;
    logic [5:0] prod;

    // GF(8) multiply, normal basis; 1 = 3'b111.
    function automatic logic [2:0] gf8_mul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] c;
        c[0] = (a[2] & b[2]) ^ (a[0] & b[1]) ^ (a[1] & b[0]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
        c[1] = (a[0] & b[0]) ^ (a[0] & b[2]) ^ (a[2] & b[0]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
        c[2] = (a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[2]) ^ (a[2] & b[0]);
        return c;
    endfunction

    // GF(64) = GF(8)[B]/(B^2+B+1), basis {B, B^2}: [2:0] is B, [5:3] is B^2.
    function automatic logic [5:0] gf64_mul(input logic [5:0] a, input logic [5:0] b);
        logic [2:0] ll, lh, hl, hh;
        ll = gf8_mul(a[2:0], b[2:0]);
        lh = gf8_mul(a[2:0], b[5:3]);
        hl = gf8_mul(a[5:3], b[2:0]);
        hh = gf8_mul(a[5:3], b[5:3]);
        return {ll ^ lh ^ hl, hh ^ lh ^ hl};
    endfunction

    function automatic logic [5:0] ninv(input logic [5:0] y);
        logic [5:0] p;
        p[0] = y[0] ^ y[1] ^ y[2] ^ y[3] ^ y[4];
        p[1] = p[0] ^ y[5];
        p[2] = y[0] ^ y[1] ^ y[5];
        p[3] = y[3] ^ y[4] ^ y[5];
        p[4] = y[0] ^ y[4];
        p[5] = y[4] ^ y[5];
        return p;
    endfunction

    function automatic logic [5:0] minv(input logic [5:0] w);
        logic [5:0] x;
        x[0] = w[0] ^ w[1] ^ w[5];
        x[1] = w[0] ^ w[1] ^ w[2] ^ w[4];
        x[2] = w[2] ^ w[4];
        x[3] = w[0] ^ w[1] ^ w[2] ^ w[3] ^ w[4] ^ w[5];
        x[4] = w[1] ^ w[2];
        x[5] = w[0] ^ w[2] ^ w[4] ^ w[5];
        return x;
    endfunction

    // Step 2 is the only multiply by the base; every other step squares.
    assign mul_b = (step_q == 3'd2) ? base_q : acc_q;
    assign prod  = gf64_mul(acc_q, mul_b);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        acc_d       = acc_q;
        base_d      = base_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    base_d  = ninv(in_data);
                    acc_d   = ninv(in_data);
                    step_d  = 3'd0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                acc_d = prod;
                if (step_q == 3'd5) begin
                    out_data_d  = minv(prod);
                    out_valid_d = 1'b1;
                    step_d      = 3'd0;
                    state_d     = StDone;
                end else begin
                    step_d = 3'(step_q + 3'd1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
`ifdef SMSS32_INV_ZEROIZE_EN
                    out_data_d  = 6'h00;
                    acc_d       = 6'h00;
                    base_d      = 6'h00;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            step_q      <= 3'd0;
            acc_q       <= 6'h00;
            base_q      <= 6'h00;
            out_data_q  <= 6'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Gated by rst so nothing is offered while reset is still asserted.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == StCalc) || (state_q == StDone);

endmodule
